// File: rtl/alu_issue_if.sv
// Issue-unit bus: instruction handshake in, ALU operands out, ALU result in, writeback out.
// The issue unit (slave) consumes instructions and ALU results; the master side is fetch + ALU.
interface alu_issue_if #(
    parameter int XLEN = 32
);
    logic            instr_valid;
    logic [31:0]     instr;
    logic            instr_ready;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [6:0]      alu_opcode;
    logic [2:0]      alu_funct3;
    logic [XLEN-1:0] alu_result;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    modport slave (
        input  instr_valid, instr, alu_result,
        output instr_ready, alu_a, alu_b, alu_opcode, alu_funct3,
               wb_valid, wb_rd, wb_data
    );

    modport master (
        output instr_valid, instr, alu_result,
        input  instr_ready, alu_a, alu_b, alu_opcode, alu_funct3,
               wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/alu_issue.sv
// RV32 issue/writeback unit for LUI, ADDI and ANDI: decodes, presents registered ALU
// operands, captures the ALU result and writes it back to a 32x32 register file.
module alu_issue #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    alu_issue_if.slave      bus,
    input  logic [4:0]      i_dbg_addr,
    output logic [XLEN-1:0] o_dbg_data,
    output logic            o_illegal,
    output logic [XLEN-1:0] o_retired_count
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_rf [NREGS];
    logic [XLEN-1:0] r_alu_a;
    logic [XLEN-1:0] r_alu_b;
    logic [6:0]      r_alu_opcode;
    logic [2:0]      r_alu_funct3;
    logic            r_wb_valid;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;
    logic            r_illegal;
    logic [XLEN-1:0] r_retired;

    logic            w_ready;
    logic            w_hs;
    logic            w_legal;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;

    function automatic logic is_legal(input logic [31:0] ins);
        logic ok;
        case (ins[6:0])
            OPC_LUI:    ok = 1'b1;
            OPC_OP_IMM: ok = (ins[14:12] == 3'b000) || (ins[14:12] == 3'b111);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign w_ready = (r_state == S_IDLE) && !i_reset;
    assign w_hs    = bus.instr_valid && w_ready;
    assign w_legal = is_legal(r_instr);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an unsupported instruction returns straight to IDLE from DECODE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_hs) w_state_nxt = S_DECODE;
                else      w_state_nxt = S_IDLE;
            end
            S_DECODE: begin
                if (w_legal) w_state_nxt = S_EXEC;
                else         w_state_nxt = S_IDLE;
            end
            S_EXEC:  w_state_nxt = S_WB;
            S_WB:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand build from the latched instruction; x0 always reads as zero.
    always_comb begin
        w_rs1_val = {XLEN{1'b0}};
        w_op_a    = {XLEN{1'b0}};
        w_op_b    = {XLEN{1'b0}};
        if (r_instr[19:15] != 5'd0) w_rs1_val = r_rf[r_instr[19:15]];
        else                        w_rs1_val = {XLEN{1'b0}};
        case (r_instr[6:0])
            OPC_LUI: begin
                w_op_a = {r_instr[31:12], 12'b0};
                w_op_b = {XLEN{1'b0}};
            end
            OPC_OP_IMM: begin
                w_op_a = w_rs1_val;
                w_op_b = {{(XLEN-12){r_instr[31]}}, r_instr[31:20]};
            end
            default: begin
                w_op_a = {XLEN{1'b0}};
                w_op_b = {XLEN{1'b0}};
            end
        endcase
    end

    // Datapath: instruction latch, ALU operand/result registers, writeback and retire count.
    // The illegal flag is decoded at handshake so its registered pulse lands in the DECODE cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_instr      <= 32'd0;
            r_alu_a      <= {XLEN{1'b0}};
            r_alu_b      <= {XLEN{1'b0}};
            r_alu_opcode <= 7'd0;
            r_alu_funct3 <= 3'd0;
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= 5'd0;
            r_wb_data    <= {XLEN{1'b0}};
            r_illegal    <= 1'b0;
            r_retired    <= {XLEN{1'b0}};
            for (int i = 0; i < NREGS; i++) r_rf[i] <= {XLEN{1'b0}};
        end else begin
            r_illegal  <= w_hs && !is_legal(bus.instr);
            r_wb_valid <= (r_state == S_EXEC);
            if (w_hs) r_instr <= bus.instr;
            if ((r_state == S_DECODE) && w_legal) begin
                r_alu_a      <= w_op_a;
                r_alu_b      <= w_op_b;
                r_alu_opcode <= r_instr[6:0];
                r_alu_funct3 <= r_instr[14:12];
            end
            if (r_state == S_EXEC) begin
                r_wb_data <= bus.alu_result;
                r_wb_rd   <= r_instr[11:7];
            end
            if (r_state == S_WB) begin
                if (r_wb_rd != 5'd0) r_rf[r_wb_rd] <= r_wb_data;
                r_retired <= r_retired + {{(XLEN-1){1'b0}}, 1'b1};
            end
        end
    end

    // Debug read port, combinational.
    always_comb begin
        o_dbg_data = {XLEN{1'b0}};
        if (i_dbg_addr != 5'd0) o_dbg_data = r_rf[i_dbg_addr];
        else                    o_dbg_data = {XLEN{1'b0}};
    end

    assign bus.instr_ready = w_ready;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_opcode  = r_alu_opcode;
    assign bus.alu_funct3  = r_alu_funct3;
    assign bus.wb_valid    = r_wb_valid;
    assign bus.wb_rd       = r_wb_rd;
    assign bus.wb_data     = r_wb_data;
    assign o_illegal       = r_illegal;
    assign o_retired_count = r_retired;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: a small ALU model answers the operands, every check
// compares against hand-computed values, sampled on the falling clock edge.
module tb_alu_issue;
    logic        clk;
    logic        reset;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        illegal;
    logic [31:0] retired;
    int          n_cmp;
    int          n_err;

    alu_issue_if #(.XLEN(32)) bus ();

    alu_issue #(.XLEN(32), .NREGS(32)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .bus             (bus),
        .i_dbg_addr      (dbg_addr),
        .o_dbg_data      (dbg_data),
        .o_illegal       (illegal),
        .o_retired_count (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: LUI passes a+b (b is zero), ADDI adds, ANDI ands.
    always_comb begin
        bus.alu_result = 32'd0;
        case (bus.alu_opcode)
            7'h37:   bus.alu_result = bus.alu_a + bus.alu_b;
            7'h13:   bus.alu_result = (bus.alu_funct3 == 3'b111) ? (bus.alu_a & bus.alu_b)
                                                                 : (bus.alu_a + bus.alu_b);
            default: bus.alu_result = 32'd0;
        endcase
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = 32'd0;
        dbg_addr = 5'd1;
        repeat (3) tick();
        chk("rst_ready", {31'd0, bus.instr_ready}, 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_ready", {31'd0, bus.instr_ready}, 32'd1);

        // LUI x1,0x12345
        bus.instr_valid = 1'b1; bus.instr = 32'h123450B7;
        tick();
        bus.instr_valid = 1'b0;
        chk("lui_t1_ready", {31'd0, bus.instr_ready}, 32'd0);
        chk("lui_t1_illegal", {31'd0, illegal}, 32'd0);
        tick();
        chk("lui_alu_a", bus.alu_a, 32'h12345000);
        chk("lui_alu_b", bus.alu_b, 32'd0);
        chk("lui_opcode", {25'd0, bus.alu_opcode}, 32'h37);
        tick();
        chk("lui_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("lui_wb_rd", {27'd0, bus.wb_rd}, 32'd1);
        chk("lui_wb_data", bus.wb_data, 32'h12345000);
        chk("lui_dbg_before", dbg_data, 32'd0);
        tick();
        chk("lui_ready", {31'd0, bus.instr_ready}, 32'd1);
        chk("lui_wb_off", {31'd0, bus.wb_valid}, 32'd0);
        chk("lui_retired", retired, 32'd1);
        chk("lui_dbg_x1", dbg_data, 32'h12345000);

        // ADDI x2,x1,-1
        bus.instr_valid = 1'b1; bus.instr = 32'hFFF08113;
        tick();
        bus.instr_valid = 1'b0;
        tick();
        chk("addi_alu_a", bus.alu_a, 32'h12345000);
        chk("addi_alu_b", bus.alu_b, 32'hFFFFFFFF);
        chk("addi_funct3", {29'd0, bus.alu_funct3}, 32'd0);
        tick();
        chk("addi_wb_data", bus.wb_data, 32'h12344FFF);
        chk("addi_wb_rd", {27'd0, bus.wb_rd}, 32'd2);
        tick();
        chk("addi_retired", retired, 32'd2);

        // ANDI x3,x2,0x0F0 with instr_valid held high (and an illegal word offered) while busy
        bus.instr_valid = 1'b1; bus.instr = 32'h0F017193;
        tick();
        bus.instr = 32'h00109093;
        chk("andi_t1_ready", {31'd0, bus.instr_ready}, 32'd0);
        tick();
        chk("andi_t2_ready", {31'd0, bus.instr_ready}, 32'd0);
        chk("andi_t2_illegal", {31'd0, illegal}, 32'd0);
        chk("andi_alu_b", bus.alu_b, 32'h000000F0);
        chk("andi_funct3", {29'd0, bus.alu_funct3}, 32'd7);
        tick();
        chk("andi_t3_ready", {31'd0, bus.instr_ready}, 32'd0);
        chk("andi_wb_data", bus.wb_data, 32'h000000F0);
        chk("andi_wb_rd", {27'd0, bus.wb_rd}, 32'd3);
        tick();
        chk("andi_ready", {31'd0, bus.instr_ready}, 32'd1);
        chk("andi_retired", retired, 32'd3);

        // ADDI x0,x0,5
        bus.instr = 32'h00500013;
        dbg_addr = 5'd0;
        tick();
        bus.instr_valid = 1'b0;
        tick();
        chk("x0_alu_a", bus.alu_a, 32'd0);
        chk("x0_alu_b", bus.alu_b, 32'd5);
        tick();
        chk("x0_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("x0_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
        chk("x0_wb_data", bus.wb_data, 32'd5);
        tick();
        chk("x0_dbg", dbg_data, 32'd0);
        chk("x0_retired", retired, 32'd4);

        // SLLI (unsupported funct3)
        bus.instr_valid = 1'b1; bus.instr = 32'h00109093;
        tick();
        bus.instr_valid = 1'b0;
        chk("slli_illegal", {31'd0, illegal}, 32'd1);
        chk("slli_t1_ready", {31'd0, bus.instr_ready}, 32'd0);
        tick();
        chk("slli_illegal_off", {31'd0, illegal}, 32'd0);
        chk("slli_ready", {31'd0, bus.instr_ready}, 32'd1);
        chk("slli_alu_b_kept", bus.alu_b, 32'd5);

        // opcode 0x33 (unsupported)
        bus.instr_valid = 1'b1; bus.instr = 32'h00208033;
        tick();
        bus.instr_valid = 1'b0;
        chk("op33_illegal", {31'd0, illegal}, 32'd1);
        tick();
        chk("op33_ready", {31'd0, bus.instr_ready}, 32'd1);
        chk("op33_illegal_off", {31'd0, illegal}, 32'd0);
        tick();
        chk("op33_no_wb_a", {31'd0, bus.wb_valid}, 32'd0);
        tick();
        chk("op33_no_wb_b", {31'd0, bus.wb_valid}, 32'd0);
        chk("op33_retired", retired, 32'd4);

        // LUI x5,0xABCDE aborted by reset during EXEC
        bus.instr_valid = 1'b1; bus.instr = 32'hABCDE2B7;
        dbg_addr = 5'd5;
        tick();
        bus.instr_valid = 1'b0;
        tick();
        chk("abort_alu_a", bus.alu_a, 32'hABCDE000);
        reset = 1'b1;
        tick();
        chk("abort_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("abort_ready_rst", {31'd0, bus.instr_ready}, 32'd0);
        chk("abort_retired", retired, 32'd0);
        chk("abort_alu_a_clr", bus.alu_a, 32'd0);
        reset = 1'b0;
        tick();
        chk("abort_ready", {31'd0, bus.instr_ready}, 32'd1);
        chk("abort_wb_off", {31'd0, bus.wb_valid}, 32'd0);
        chk("abort_dbg_x5", dbg_data, 32'd0);
        dbg_addr = 5'd2;
        tick();
        chk("abort_dbg_x2", dbg_data, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
# alu_issue

Instruction issue/writeback unit that drives the RV32 ALU: accepts one instruction word per valid/ready handshake and decodes LUI, ADDI and ANDI. Reads rs1 from an internal 32×32 register file, builds the immediate and presents `alu_a`/`alu_b`/`alu_opcode`/`alu_funct3` to the ALU. Captures `alu_result` and writes it back to rd. Sits between instruction fetch and the ALU; it is the producer of every ALU operand and the consumer of every ALU result.

## Interface

Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.
- `NREGS`, 32, register count; x0 is hardwired to zero.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high.
- `instr_valid`  input  1  instruction word offered.
- `instr`  input  32  RV32 instruction word.
- `instr_ready`  output  1  unit can accept an instruction.
- `alu_a`  output  32  ALU operand a, registered.
- `alu_b`  output  32  ALU operand b, registered.
- `alu_opcode`  output  7  instr[6:0], registered.
- `alu_funct3`  output  3  instr[14:12], registered.
- `alu_result`  input  32  combinational ALU result.
- `wb_valid`  output  1  one-cycle writeback strobe.
- `wb_rd`  output  5  writeback destination.
- `wb_data`  output  32  writeback value.
- `illegal`  output  1  one-cycle pulse on an unsupported instruction.
- `retired_count`  output  32  count of retired legal instructions.
- `dbg_addr`  input  5  debug register-file read address.
- `dbg_data`  output  32  combinational read of x[`dbg_addr`]; x0 reads 0.

## Operation

- FSM states: IDLE → DECODE → EXEC → WB → IDLE. Illegal path: DECODE → IDLE.
- IDLE:
  - `instr_ready`=1 (0 while `reset` is high).
  - A handshake (`instr_valid` & `instr_ready`) latches `instr` into the instruction register; next state is DECODE.
- DECODE:
  - Reads rs1 = instr[19:15].
  - LUI (0110111): `alu_a`={instr[31:12],12'b0}, `alu_b`=0.
  - OP_IMM (0010011) with funct3 000 or 111: `alu_a`=x[rs1], `alu_b`=sign-extend(instr[31:20]).
  - Registers `alu_opcode`/`alu_funct3`; next state is EXEC.
  - Any other opcode, or OP_IMM with any other funct3: `illegal`=1 for this cycle only, `alu_*` unchanged, next state is IDLE.
- EXEC: `wb_data`←`alu_result`, `wb_rd`←instr[11:7]; next state is WB.
- WB:
  - `wb_valid`=1.
  - x[rd] is written at the end of the cycle unless rd=0.
  - `retired_count` increments.
  - Next state is IDLE.
- `instr_ready`=0 in DECODE/EXEC/WB; `instr_valid` is ignored while busy.
- Arithmetic is modulo 2^32 and is performed by the ALU. `retired_count` wraps 0xFFFFFFFF→0.
- Reset (any state, including mid-instruction):
  - state←IDLE.
  - All 32 registers←0.
  - `alu_a`, `alu_b`, `alu_opcode`, `alu_funct3`, `wb_rd`, `wb_data`, `retired_count` ← 0.
  - `wb_valid`=0, `illegal`=0.
  - The in-flight instruction is discarded: no writeback, no count.

## Timing

- Handshake in cycle T.
- T+1: DECODE; `illegal` is asserted here if applicable.
- T+2: EXEC; `alu_*` valid throughout; `alu_result` sampled at the end of T+2.
- T+3: WB; `wb_valid`=1 and `wb_rd`/`wb_data` valid. Register-file write and count update land at the end of T+3.
- T+4: IDLE, `instr_ready`=1. Throughput is one instruction per 4 cycles.
- Illegal instruction: IDLE with `instr_ready`=1 again at T+2.
- Read-after-write: the next instruction decodes no earlier than T+5 and sees the updated register; no forwarding is needed.
- `dbg_data` reflects a write from the cycle after WB.

## Test plan

- Reset, then LUI x1,0x12345 (0x123450B7) → at T+3 `wb_valid`=1, `wb_rd`=1, `wb_data`=0x12345000; `retired_count`=1; `dbg_data`[x1]=0x12345000.
- Then ADDI x2,x1,-1 (0xFFF08113) → `alu_b`=0xFFFFFFFF during EXEC; `wb_data`=0x12344FFF; `retired_count`=2.
- Then ANDI x3,x2,0x0F0 (0x0F017193) → `wb_data`=0x000000F0, `wb_rd`=3; `instr_ready` low T+1..T+3 while `instr_valid` is held high.
- ADDI x0,x0,5 (0x00500013) → `wb_valid` pulses with `wb_rd`=0, `wb_data`=5; `dbg_data`[x0] stays 0.
- SLLI 0x00109093, then opcode 0x33 (0x00208033) → `illegal` pulse at T+1 for each; no `wb_valid`; `retired_count` unchanged; `instr_ready`=1 at T+2.
- `reset` asserted during EXEC of LUI x5 → no `wb_valid`; x5=0; `retired_count`=0; `instr_ready`=1 the cycle after `reset` deasserts.
